// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory.
// Data port wins by default; fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_DONE,
  input  logic        DM_REQ,
  input  logic        DM_WE,
  input  logic [3:0]  DM_BE,
  input  logic [31:0] DM_ADDR,
  input  logic [31:0] DM_WDATA,
  output logic [31:0] DM_RDATA,
  output logic        DM_DONE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic        BUSY
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_DM,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        dm_win;

  assign dm_win = DM_REQ && (!IF_REQ || (starve_q < LIMIT));

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_win) begin
          state_d = GNT_DM;
          we_d    = DM_WE;
          be_d    = DM_BE;
          addr_d  = DM_ADDR;
          wdata_d = DM_WDATA;
          if (!IF_REQ) begin
            starve_d = 3'd0;
          end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (IF_REQ) begin
          state_d  = GNT_IF;
          we_d     = 1'b0;
          be_d     = 4'b1111;
          addr_d   = IF_ADDR;
          wdata_d  = 32'd0;
          starve_d = 3'd0;
        end
      end
      GNT_IF: begin
        if (MEM_ACK) begin
          if_rdata_d = MEM_RDATA;
          if_done_d  = 1'b1;
          state_d    = RESP;
        end
      end
      GNT_DM: begin
        if (MEM_ACK) begin
          // writes leave the last read word visible
          if (!we_q) begin
            dm_rdata_d = MEM_RDATA;
          end
          dm_done_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  assign MEM_REQ   = (state_q == GNT_IF) || (state_q == GNT_DM);
  assign MEM_WE    = we_q;
  assign MEM_BE    = be_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign IF_RDATA  = if_rdata_q;
  assign DM_RDATA  = dm_rdata_q;
  assign IF_DONE   = if_done_q;
  assign DM_DONE   = dm_done_q;
  assign BUSY      = (state_q != IDLE);

endmodule
